// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared MNIST network dimensions and sample types
package mnist_pkg;

    localparam int DW          = 8;
    localparam int CONV1_CH    = 6;
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int POOL1_OUT_W = CONV1_OUT_W / 2;
    localparam int POOL1_OUT_H = CONV1_OUT_H / 2;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - combinational signed maximum of two samples
module pool_max2 #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    // Full-width signed compare; equal inputs return either, so ties need no special case
    always_comb begin
        y = (a > b) ? a : b;
    end

endmodule

// File: rtl/layer1_maxpool.sv
// rtl/layer1_maxpool.sv - 2x2 stride-2 streaming max-pool after conv1
module layer1_maxpool #(
    parameter int IN_W    = mnist_pkg::CONV1_OUT_W,
    parameter int IN_H    = mnist_pkg::CONV1_OUT_H,
    parameter int DW      = mnist_pkg::DW,
    parameter int RELU_EN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] in_ch0,
    input  logic signed [DW-1:0] in_ch1,
    input  logic signed [DW-1:0] in_ch2,
    input  logic signed [DW-1:0] in_ch3,
    input  logic signed [DW-1:0] in_ch4,
    input  logic signed [DW-1:0] in_ch5,
    output logic signed [DW-1:0] pool_ch0,
    output logic signed [DW-1:0] pool_ch1,
    output logic signed [DW-1:0] pool_ch2,
    output logic signed [DW-1:0] pool_ch3,
    output logic signed [DW-1:0] pool_ch4,
    output logic signed [DW-1:0] pool_ch5,
    output logic                 pool_valid,
    output logic                 frame_done
);

    import mnist_pkg::*;

    localparam int CH       = CONV1_CH;
    localparam int XW       = $clog2(IN_W);
    localparam int YW       = $clog2(IN_H);
    localparam int LB_DEPTH = IN_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    // Raster position of the sample currently on the input
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_last, y_last;

    // Per-channel datapath: hold reg, horizontal max, line-buffer read, vertical max
    logic signed [DW-1:0] in_ch  [CH];
    logic signed [DW-1:0] h_q    [CH];
    logic signed [DW-1:0] h_d    [CH];
    logic signed [DW-1:0] m      [CH];
    logic signed [DW-1:0] lb_rd  [CH];
    logic signed [DW-1:0] v      [CH];
    logic signed [DW-1:0] pool_q [CH];
    logic signed [DW-1:0] pool_d [CH];

    logic pool_valid_q, pool_valid_d;
    logic frame_done_q, frame_done_d;

    // One entry per output column holding the half-pooled even row of all channels
    logic [CH*DW-1:0] linebuf_q [LB_DEPTH];
    logic [CH*DW-1:0] lb_wdata;
    logic [AW-1:0]    lb_addr;
    logic             lb_we;

    assign in_ch[0] = in_ch0;
    assign in_ch[1] = in_ch1;
    assign in_ch[2] = in_ch2;
    assign in_ch[3] = in_ch3;
    assign in_ch[4] = in_ch4;
    assign in_ch[5] = in_ch5;

    assign x_last  = (x_q == XW'(IN_W - 1));
    assign y_last  = (y_q == YW'(IN_H - 1));
    assign lb_addr = AW'(x_q >> 1);
    assign lb_we   = valid_in && x_q[0] && !y_q[0];

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign lb_rd[g]             = $signed(linebuf_q[lb_addr][g*DW +: DW]);
        assign lb_wdata[g*DW +: DW] = m[g];

        pool_max2 #(.W(DW)) u_hmax (
            .a (h_q[g]),
            .b (in_ch[g]),
            .y (m[g])
        );

        pool_max2 #(.W(DW)) u_vmax (
            .a (m[g]),
            .b (lb_rd[g]),
            .y (v[g])
        );
    end

    // Next-state: raster counters, hold regs and the registered pooled output
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        pool_valid_d = valid_in && x_q[0] && y_q[0];
        frame_done_d = pool_valid_d && x_last && y_last;
        for (int c = 0; c < CH; c++) begin
            h_d[c]    = h_q[c];
            pool_d[c] = pool_q[c];
            if (valid_in && !x_q[0]) begin
                h_d[c] = in_ch[c];
            end
            if (pool_valid_d) begin
                pool_d[c] = ((RELU_EN != 0) && (v[c] < 0)) ? '0 : v[c];
            end
        end
        if (valid_in) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial window mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                h_q[c]    <= '0;
                pool_q[c] <= '0;
            end
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            pool_valid_q <= pool_valid_d;
            frame_done_q <= frame_done_d;
            for (int c = 0; c < CH; c++) begin
                h_q[c]    <= h_d[c];
                pool_q[c] <= pool_d[c];
            end
        end
    end

    // Line buffer write on even rows; contents need no reset
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_addr] <= lb_wdata;
        end
    end

    assign pool_ch0   = pool_q[0];
    assign pool_ch1   = pool_q[1];
    assign pool_ch2   = pool_q[2];
    assign pool_ch3   = pool_q[3];
    assign pool_ch4   = pool_q[4];
    assign pool_ch5   = pool_q[5];
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;

endmodule
